// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the two-requester AXI read-channel arbiter:
// FSM state encoding, burst/response codes and requester identifiers.
package axi_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    // Bit index of each requester inside the one-hot grant vector.
    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_t;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI-style read channel bundle (AR + R). The "master" modport is the side
// that issues addresses; the "slave" modport is the side that returns data.
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic [1:0]        arburst;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rlast;
    logic              rready;

    modport master (
        output araddr, arvalid, arburst, arlen, arsize, rready,
        input  arready, rdata, rresp, rvalid, rlast
    );

    modport slave (
        input  araddr, arvalid, arburst, arlen, arsize, rready,
        output arready, rdata, rresp, rvalid, rlast
    );
endinterface

// File: rtl/axi_rd_arbiter_arb_pick.sv
// Winner selection for the read arbiter.
// Default build: fixed priority, dcache (m1) beats icache (m0).
// With AXI_ARB_RR_EN defined: round-robin, the requester that did not own
// the last completed burst wins a tie.
module arb_pick
    import axi_rd_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] win
);

`ifdef AXI_ARB_RR_EN
    // On a tie hand the bus to whoever did not finish the previous burst.
    always_comb begin
        win = 2'b00;
        if (req == 2'b11) begin
            win = last_owner ? 2'b01 : 2'b10;
        end else begin
            win = req;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    // The dcache always wins a tie; the icache only wins when alone.
    always_comb begin
        win = 2'b00;
        if (req[REQ_DC]) begin
            win[REQ_DC] = 1'b1;
        end else if (req[REQ_IC]) begin
            win[REQ_IC] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI-style read channel between the icache (m0) and the dcache
// (m1). A grant is held from the AR handshake through the rlast beat, and
// the burst length is checked against arlen (sticky proto_err).
// Optional round-robin arbitration is enabled by defining AXI_ARB_RR_EN.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    axi_rd_arbiter_if.slave   m0,
    axi_rd_arbiter_if.slave   m1,
    axi_rd_arbiter_if.master  s,
    output logic              busy,
    output logic [1:0]        grant,
    output logic              proto_err
);

    arb_state_t        state_q, state_d;
    logic [1:0]        grant_q;
    logic [7:0]        len_q;
    logic [8:0]        beat_cnt_q;
    logic              proto_err_q;
    logic              last_owner;

    logic [1:0]        req;
    logic [1:0]        win;
    logic              sel_dc;
    logic [ADDR_W-1:0] sel_araddr;
    logic              sel_arvalid;
    logic [7:0]        sel_arlen;
    logic              sel_rready;
    logic              ar_hs;
    logic              r_hs;
    logic              last_hs;

    assign req         = {m1.arvalid, m0.arvalid};
    assign sel_dc      = grant_q[REQ_DC];
    assign sel_araddr  = sel_dc ? m1.araddr  : m0.araddr;
    assign sel_arvalid = sel_dc ? m1.arvalid : m0.arvalid;
    assign sel_arlen   = sel_dc ? m1.arlen   : m0.arlen;
    assign sel_rready  = sel_dc ? m1.rready  : m0.rready;

    assign ar_hs   = (state_q == ADDR) && sel_arvalid && s.arready;
    assign r_hs    = (state_q == DATA) && s.rvalid && sel_rready;
    assign last_hs = r_hs && s.rlast;

    arb_pick u_pick (
        .req        (req),
        .last_owner (last_owner),
        .win        (win)
    );

`ifdef AXI_ARB_RR_EN
    logic last_owner_q;

    // Remember which requester owned the most recently completed burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_owner_q <= 1'b0;
        end else if (last_hs) begin
            last_owner_q <= grant_q[REQ_DC];
        end
    end

    assign last_owner = last_owner_q;
`else
    assign last_owner = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: arbitrate in IDLE, wait for AR handshake, then for rlast.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req)   state_d = ADDR;
            ADDR:    if (ar_hs)  state_d = DATA;
            DATA:    if (last_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant ownership, captured burst length, beat counter and error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q     <= 2'b00;
            len_q       <= 8'd0;
            beat_cnt_q  <= 9'd0;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) grant_q <= win;
                end
                ADDR: begin
                    if (ar_hs) begin
                        len_q      <= sel_arlen;
                        beat_cnt_q <= 9'd0;
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt_q <= beat_cnt_q + 9'd1;
                        if (s.rlast && (beat_cnt_q != {1'b0, len_q})) proto_err_q <= 1'b1;
                        if (!s.rlast && (beat_cnt_q == {1'b0, len_q})) proto_err_q <= 1'b1;
                        if (s.rlast) grant_q <= 2'b00;
                    end
                end
                default: grant_q <= 2'b00;
            endcase
        end
    end

    // Channel steering: AR forwarded in ADDR, R forwarded in DATA, else idle.
    always_comb begin
        s.araddr   = {ADDR_W{1'b0}};
        s.arvalid  = 1'b0;
        s.arburst  = 2'b00;
        s.arlen    = 8'd0;
        s.arsize   = 3'd0;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m0.rdata   = {DATA_W{1'b0}};
        m0.rresp   = 2'b00;
        m0.rvalid  = 1'b0;
        m0.rlast   = 1'b0;
        m1.arready = 1'b0;
        m1.rdata   = {DATA_W{1'b0}};
        m1.rresp   = 2'b00;
        m1.rvalid  = 1'b0;
        m1.rlast   = 1'b0;
        case (state_q)
            ADDR: begin
                s.araddr  = sel_araddr;
                s.arvalid = sel_arvalid;
                s.arburst = sel_dc ? m1.arburst : m0.arburst;
                s.arlen   = sel_arlen;
                s.arsize  = sel_dc ? m1.arsize : m0.arsize;
                if (sel_dc) m1.arready = s.arready;
                else        m0.arready = s.arready;
            end
            DATA: begin
                s.rready = sel_rready;
                if (sel_dc) begin
                    m1.rdata  = s.rdata;
                    m1.rresp  = s.rresp;
                    m1.rvalid = s.rvalid;
                    m1.rlast  = s.rlast;
                end else begin
                    m0.rdata  = s.rdata;
                    m0.rresp  = s.rresp;
                    m0.rvalid = s.rvalid;
                    m0.rlast  = s.rlast;
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;
    assign proto_err = proto_err_q;

endmodule
